// File: rtl/pixel_scheduler_if.sv
// Pixel result stream between the scheduler and the colour-map stage.
// master drives pix_valid/x/y/depth/last; slave drives pix_ready.
interface pixel_scheduler_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [9:0] pix_depth;
    logic       pix_last;

    modport master (
        output pix_valid,
        output pix_x,
        output pix_y,
        output pix_depth,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_x,
        input  pix_y,
        input  pix_depth,
        input  pix_last,
        output pix_ready
    );
endinterface

// File: rtl/pixel_scheduler.sv
// Frame scheduler: raster walk, c generation, engine dispatch, in-order collect.
// Ports: sysclk, reset_n (async, active-low), frame_start, re_origin,
//   im_origin, step, max_iter_in; engine bank eng_start/eng_re_c/eng_im_c/
//   eng_max_iter/eng_done/eng_depth; pix (pixel stream, master); busy.
// Optional: SCHED_PERF_EN adds perf_cycles and perf_iter_sum.
module pixel_scheduler #(
    parameter int N_ENGINES   = 4,
    parameter int WORD_LENGTH = 32,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic                              sysclk,
    input  logic                              reset_n,
    input  logic                              frame_start,
    input  logic signed [WORD_LENGTH-1:0]     re_origin,
    input  logic signed [WORD_LENGTH-1:0]     im_origin,
    input  logic signed [WORD_LENGTH-1:0]     step,
    input  logic [9:0]                        max_iter_in,
    output logic [N_ENGINES-1:0]              eng_start,
    output logic [N_ENGINES*WORD_LENGTH-1:0]  eng_re_c,
    output logic [N_ENGINES*WORD_LENGTH-1:0]  eng_im_c,
    output logic [9:0]                        eng_max_iter,
    input  logic [N_ENGINES-1:0]              eng_done,
    input  logic [N_ENGINES*10-1:0]           eng_depth,
    pixel_scheduler_if.master                 pix,
    output logic                              busy
`ifdef SCHED_PERF_EN
    ,
    output logic [31:0]                       perf_cycles,
    output logic [31:0]                       perf_iter_sum
`endif
);

    localparam int PW = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
    localparam logic [9:0] LAST_X = 10'(H_RES - 1);
    localparam logic [8:0] LAST_Y = 9'(V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } fsm_t;

    typedef enum logic [1:0] {
        SL_FREE,
        SL_GUARD,
        SL_BUSY,
        SL_DONE
    } slot_t;

    fsm_t                          state;
    slot_t                         slot_st [N_ENGINES];
    logic [9:0]                    slot_x  [N_ENGINES];
    logic [8:0]                    slot_y  [N_ENGINES];
    logic [9:0]                    slot_d  [N_ENGINES];

    logic [PW-1:0]                 disp_ptr;
    logic [PW-1:0]                 col_ptr;
    logic [9:0]                    gen_x;
    logic [8:0]                    gen_y;
    logic signed [WORD_LENGTH-1:0] re_org;
    logic signed [WORD_LENGTH-1:0] step_r;
    logic signed [WORD_LENGTH-1:0] re_acc;
    logic signed [WORD_LENGTH-1:0] im_acc;

    logic disp_go;
    logic col_go;
    logic accept;
    logic gen_last;
    logic frame_end;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N_ENGINES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign gen_last  = (gen_x == LAST_X) && (gen_y == LAST_Y);
    assign disp_go   = (state == S_RUN) && (slot_st[disp_ptr] == SL_FREE);
    assign accept    = pix.pix_valid && pix.pix_ready;
    // Collect only from the head slot, so results leave in raster order.
    assign col_go    = (state != S_IDLE)
                     && (slot_st[col_ptr] == SL_DONE)
                     && (!pix.pix_valid || pix.pix_ready);
    assign frame_end = (state == S_DRAIN) && accept && pix.pix_last;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            eng_start     <= '0;
            eng_re_c      <= '0;
            eng_im_c      <= '0;
            eng_max_iter  <= '0;
            re_org        <= '0;
            step_r        <= '0;
            re_acc        <= '0;
            im_acc        <= '0;
            gen_x         <= '0;
            gen_y         <= '0;
            disp_ptr      <= '0;
            col_ptr       <= '0;
            pix.pix_valid <= 1'b0;
            pix.pix_x     <= '0;
            pix.pix_y     <= '0;
            pix.pix_depth <= '0;
            pix.pix_last  <= 1'b0;
            for (int i = 0; i < N_ENGINES; i++) begin
                slot_st[i] <= SL_FREE;
                slot_x[i]  <= '0;
                slot_y[i]  <= '0;
                slot_d[i]  <= '0;
            end
        end else begin
            eng_start <= '0;

            for (int i = 0; i < N_ENGINES; i++) begin
                unique case (slot_st[i])
                    // Engine done still shows the previous pixel here.
                    SL_GUARD: slot_st[i] <= SL_BUSY;
                    SL_BUSY: begin
                        if (eng_done[i]) begin
                            slot_st[i] <= SL_DONE;
                            slot_d[i]  <= eng_depth[i*10 +: 10];
                        end
                    end
                    default: ;
                endcase

                if (disp_go && (disp_ptr == PW'(i))) begin
                    slot_st[i]   <= SL_GUARD;
                    slot_x[i]    <= gen_x;
                    slot_y[i]    <= gen_y;
                    eng_start[i] <= 1'b1;
                    eng_re_c[i*WORD_LENGTH +: WORD_LENGTH] <= re_acc;
                    eng_im_c[i*WORD_LENGTH +: WORD_LENGTH] <= im_acc;
                end

                if (col_go && (col_ptr == PW'(i))) begin
                    slot_st[i] <= SL_FREE;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state        <= S_RUN;
                        busy         <= 1'b1;
                        eng_max_iter <= max_iter_in;
                        re_org       <= re_origin;
                        step_r       <= step;
                        re_acc       <= re_origin;
                        im_acc       <= im_origin;
                        gen_x        <= '0;
                        gen_y        <= '0;
                        disp_ptr     <= '0;
                        col_ptr      <= '0;
                    end
                end
                S_RUN: begin
                    if (disp_go) begin
                        disp_ptr <= ptr_inc(disp_ptr);
                        if (gen_x != LAST_X) begin
                            gen_x  <= gen_x + 1'b1;
                            re_acc <= re_acc + step_r;
                        end else begin
                            gen_x  <= '0;
                            re_acc <= re_org;
                            gen_y  <= gen_y + 1'b1;
                            im_acc <= im_acc - step_r;
                        end
                        if (gen_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (frame_end) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (col_go) begin
                pix.pix_valid <= 1'b1;
                pix.pix_x     <= slot_x[col_ptr];
                pix.pix_y     <= slot_y[col_ptr];
                pix.pix_depth <= slot_d[col_ptr];
                pix.pix_last  <= (slot_x[col_ptr] == LAST_X)
                              && (slot_y[col_ptr] == LAST_Y);
                col_ptr       <= ptr_inc(col_ptr);
            end else if (pix.pix_ready) begin
                pix.pix_valid <= 1'b0;
            end
        end
    end

`ifdef SCHED_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] sum_acc;
    logic [32:0] sum_nxt;
    logic [31:0] sum_sat;

    assign sum_nxt = {1'b0, sum_acc} + {23'd0, pix.pix_depth};
    assign sum_sat = sum_nxt[32] ? '1 : sum_nxt[31:0];

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt       <= '0;
            sum_acc       <= '0;
            perf_cycles   <= '0;
            perf_iter_sum <= '0;
        end else if ((state == S_IDLE) && frame_start) begin
            cyc_cnt       <= '0;
            sum_acc       <= '0;
            perf_cycles   <= '0;
            perf_iter_sum <= '0;
        end else if (state != S_IDLE) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (accept) begin
                sum_acc <= sum_sat;
            end
            // Count includes the accepting edge itself.
            if (frame_end) begin
                perf_cycles   <= cyc_cnt + 1'b1;
                perf_iter_sum <= sum_sat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler: 4 engines, 4x2 frame.
// Behavioural engines derive depth x+y back from the dispatched c.
module tb_pixel_scheduler;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int HR = 4;
    localparam int VR = 2;
    localparam int NPIX = HR * VR;

    logic                 sysclk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 frame_start = 1'b0;
    logic signed [W-1:0]  re_origin = '0;
    logic signed [W-1:0]  im_origin = '0;
    logic signed [W-1:0]  step = '0;
    logic [9:0]           max_iter_in = '0;
    logic [N-1:0]         eng_start;
    logic [N*W-1:0]       eng_re_c;
    logic [N*W-1:0]       eng_im_c;
    logic [9:0]           eng_max_iter;
    logic [N-1:0]         eng_done = '0;
    logic [N*10-1:0]      eng_depth = '0;
    logic                 busy;
`ifdef SCHED_PERF_EN
    logic [31:0]          perf_cycles;
    logic [31:0]          perf_iter_sum;
`endif

    pixel_scheduler_if pif ();

    pixel_scheduler #(
        .N_ENGINES   (N),
        .WORD_LENGTH (W),
        .H_RES       (HR),
        .V_RES       (VR)
    ) dut (
        .sysclk       (sysclk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .re_origin    (re_origin),
        .im_origin    (im_origin),
        .step         (step),
        .max_iter_in  (max_iter_in),
        .eng_start    (eng_start),
        .eng_re_c     (eng_re_c),
        .eng_im_c     (eng_im_c),
        .eng_max_iter (eng_max_iter),
        .eng_done     (eng_done),
        .eng_depth    (eng_depth),
        .pix          (pif.master),
        .busy         (busy)
`ifdef SCHED_PERF_EN
        ,
        .perf_cycles   (perf_cycles),
        .perf_iter_sum (perf_iter_sum)
`endif
    );

    always #5 sysclk = ~sysclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---- behavioural engines ----
    int          lat [N];
    int          e_cnt [N];
    logic [9:0]  e_dep [N];
    bit          const_mode = 1'b0;
    logic signed [W-1:0] cur_reo, cur_imo, cur_st;

    function automatic logic [9:0] model_depth(input logic signed [W-1:0] re,
                                               input logic signed [W-1:0] im);
        logic signed [W-1:0] dr;
        logic signed [W-1:0] di;
        if (const_mode) return 10'd2;
        dr = re - cur_reo;
        di = cur_imo - im;
        return 10'(dr / cur_st + di / cur_st);
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            e_cnt[i] = 0;
            e_dep[i] = '0;
            lat[i]   = 5;
        end
    end

    always @(posedge sysclk) begin
        for (int i = 0; i < N; i++) begin
            if (eng_start[i]) begin
                e_cnt[i]    <= lat[i];
                eng_done[i] <= 1'b0;
                e_dep[i]    <= model_depth(eng_re_c[i*W +: W], eng_im_c[i*W +: W]);
            end else if (e_cnt[i] != 0) begin
                e_cnt[i] <= e_cnt[i] - 1;
                if (e_cnt[i] == 1) begin
                    eng_done[i]          <= 1'b1;
                    eng_depth[i*10 +: 10] <= e_dep[i];
                end
            end
        end
    end

    // ---- monitor: beats and engine starts ----
    int          beat_idx = 0;
    int          depth_sum = 0;
    int          st_cnt [N];
    int          first_snap = 0;
    int          last_cyc = 0;
    int          fs_cyc = 0;
    logic [W-1:0] cap_re3 = '0;
    logic [W-1:0] cap_im3 = '0;

    initial for (int i = 0; i < N; i++) st_cnt[i] = 0;

    always @(negedge sysclk) begin
        if (reset_n && pif.pix_valid && pif.pix_ready) begin
            logic [9:0] ex_x;
            logic [8:0] ex_y;
            logic [9:0] ex_d;
            ex_x = 10'(beat_idx % HR);
            ex_y = 9'(beat_idx / HR);
            ex_d = const_mode ? 10'd2 : 10'(ex_x + 10'(ex_y));
            check("beat", {pif.pix_x, pif.pix_y, pif.pix_depth, pif.pix_last},
                  {ex_x, ex_y, ex_d, beat_idx == NPIX - 1});
            if (beat_idx == 0)
                first_snap = st_cnt[1] + st_cnt[2] + st_cnt[3];
            if (pif.pix_last) last_cyc = cyc;
            depth_sum += int'(pif.pix_depth);
            beat_idx++;
        end
        for (int i = 0; i < N; i++) begin
            if (eng_start[i]) begin
                if (i == 3 && st_cnt[3] == 1) begin
                    cap_re3 = eng_re_c[3*W +: W];
                    cap_im3 = eng_im_c[3*W +: W];
                end
                st_cnt[i]++;
            end
        end
    end

    function automatic int starts_total();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += st_cnt[i];
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic start_frame(input logic signed [W-1:0] reo,
                               input logic signed [W-1:0] imo,
                               input logic signed [W-1:0] st,
                               input logic [9:0] mi);
        beat_idx   = 0;
        depth_sum  = 0;
        first_snap = 0;
        for (int i = 0; i < N; i++) st_cnt[i] = 0;
        re_origin   = reo;
        im_origin   = imo;
        step        = st;
        max_iter_in = mi;
        cur_reo     = reo;
        cur_imo     = imo;
        cur_st      = st;
        frame_start = 1'b1;
        fs_cyc      = cyc;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 3000) begin
            tick(1);
            k++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: busy still high after %0d cycles", name, k);
        end
    endtask

    typedef struct {
        logic signed [W-1:0] reo;
        logic signed [W-1:0] imo;
        logic signed [W-1:0] st;
        logic [9:0]          mi;
        int                  l0, l1, l2, l3;
        int                  exp_beats;
        int                  exp_sum;
    } vec_t;

    vec_t vt [4];

    initial begin
        logic [9:0] sx, sy, sd;
        int s0;
        bit stable;

        vt[0] = '{32'sd0, 32'sd0, 32'sd1, 10'd100, 5, 5, 5, 5, NPIX, 16};
        vt[1] = '{32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 10'd1023,
                  40, 3, 3, 3, NPIX, 16};
        vt[2] = '{32'h7FFF_FFFE, 32'h8000_0001, 32'sd3, 10'd7,
                  1, 7, 2, 9, NPIX, 16};
        vt[3] = '{-32'sd5, 32'sd9, -32'sd2, 10'd0, 3, 3, 3, 3, NPIX, 16};

        pif.pix_ready = 1'b1;
        tick(3);
        check("rst_start", 64'(eng_start), 64'd0);
        check("rst_rec", 64'(|eng_re_c), 64'd0);
        check("rst_imc", 64'(|eng_im_c), 64'd0);
        check("rst_pix", {eng_max_iter, pif.pix_valid, pif.pix_x, pif.pix_y,
                          pif.pix_depth, pif.pix_last, busy}, 64'd0);
        reset_n = 1'b1;
        tick(2);

        for (int v = 0; v < 4; v++) begin
            lat[0] = vt[v].l0;
            lat[1] = vt[v].l1;
            lat[2] = vt[v].l2;
            lat[3] = vt[v].l3;
            start_frame(vt[v].reo, vt[v].imo, vt[v].st, vt[v].mi);
            check("busy_hi", 64'(busy), 64'd1);
            wait_idle("frame");
            check("beats", 64'(beat_idx), 64'(vt[v].exp_beats));
            check("dsum", 64'(depth_sum), 64'(vt[v].exp_sum));
            check("starts", 64'(starts_total()), 64'(vt[v].exp_beats));
            check("maxit", 64'(eng_max_iter), 64'(vt[v].mi));
            tick(3);
            check("busy_lo", 64'(busy), 64'd0);
            if (v == 1) begin
                check("c_re31", 64'(cap_re3), 64'h0000_0000_F800_0000);
                check("c_im31", 64'(cap_im3), 64'h0000_0000_0800_0000);
                check("c_hold_re", 64'(eng_re_c[3*W +: W]), 64'h0000_0000_F800_0000);
                check("c_hold_im", 64'(eng_im_c[3*W +: W]), 64'h0000_0000_0800_0000);
                check("ooo_norestart", 64'(first_snap), 64'd3);
            end
        end

        // Backpressure: output reg plus all four slots fill, then stall.
        lat = '{5, 5, 5, 5};
        pif.pix_ready = 1'b0;
        start_frame(32'sd0, 32'sd0, 32'sd1, 10'd50);
        tick(60);
        check("bp_starts", 64'(starts_total()), 64'd5);
        check("bp_head", {pif.pix_valid, pif.pix_x, pif.pix_y}, {1'b1, 10'd0, 9'd0});
        sx = pif.pix_x;
        sy = 10'(pif.pix_y);
        sd = pif.pix_depth;
        s0 = starts_total();
        stable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (!pif.pix_valid || pif.pix_x != sx || 10'(pif.pix_y) != sy
                || pif.pix_depth != sd || eng_start != '0)
                stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_nostart", 64'(starts_total()), 64'(s0));
        pif.pix_ready = 1'b1;
        wait_idle("bp");
        check("bp_beats", 64'(beat_idx), 64'(NPIX));

        // frame_start during RUN is ignored.
        start_frame(32'sd0, 32'sd0, 32'sd1, 10'd50);
        tick(2);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        wait_idle("dup");
        tick(20);
        check("dup_beats", 64'(beat_idx), 64'(NPIX));
        check("dup_idle", 64'(busy), 64'd0);

        // Reset mid-frame aborts and silences the engines.
        start_frame(32'sd0, 32'sd0, 32'sd1, 10'd50);
        tick(4);
        reset_n = 1'b0;
        #1;
        check("mrst_out", {eng_max_iter, pif.pix_valid, pif.pix_x, pif.pix_y,
                           pif.pix_depth, pif.pix_last, busy, eng_start}, 64'd0);
        check("mrst_c", 64'(|{eng_re_c, eng_im_c}), 64'd0);
        s0 = starts_total();
        tick(5);
        reset_n = 1'b1;
        tick(20);
        check("mrst_silent", 64'(starts_total()), 64'(s0));
        check("mrst_idle", 64'(busy), 64'd0);
        start_frame(32'sd0, 32'sd0, 32'sd1, 10'd50);
        wait_idle("recover");
        check("recover_beats", 64'(beat_idx), 64'(NPIX));

`ifdef SCHED_PERF_EN
        lat = '{1, 1, 1, 1};
        const_mode = 1'b1;
        start_frame(32'sd0, 32'sd0, 32'sd1, 10'd50);
        check("perf_clr", {perf_cycles, perf_iter_sum}, 64'd0);
        wait_idle("perf");
        check("perf_sum", 64'(perf_iter_sum), 64'd16);
        check("perf_cyc", 64'(perf_cycles), 64'(last_cyc - fs_cyc));
        const_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
